uart_mem_ctrl: RTL and testbench
================================

Name: uart_mem_ctrl

Overview:
Memory-access controller that shares one uart_comm byte channel between two requesters: port 0 (instruction fetch) and port 1 (data memory). It grants one request at a time using round-robin arbitration. The granted request is serialised into a command packet on the UART send FIFO, and the response bytes are collected from the receive FIFO. Completion, read data and error status are returned to the granted port. The block sits between the CPU memory stage/IF stage and uart_comm.

Parameters:
TIMEOUT_CYCLES, 1048576, response watchdog limit in CLK cycles; used only with UART_MEM_TIMEOUT_EN.
WRITE_ACK, 1, 1 = a write waits for one ack byte; 0 = a write completes after its last byte is sent.

Ports:
CLK  input  1  clock
RST  input  1  reset
req_valid  input  2  per-port request; held until accepted
p0_write, p1_write  input  1 each  1 = write
p0_addr, p1_addr  input  32 each  byte address
p0_wdata, p1_wdata  input  32 each  write data
p0_mask, p1_mask  input  4 each  byte-enable mask
req_ready  output  2  one-hot, one-cycle pulse on accept
resp_valid  output  2  one-hot, one-cycle completion pulse
resp_rdata  output  32  read data; valid with resp_valid
resp_err  output  1  timeout flag; valid with resp_valid
send_flag  output  1  write strobe to the uart_comm send FIFO
send_data  output  8  byte to send
sendable  input  1  send FIFO not full
recv_flag  output  1  pop strobe to the uart_comm receive FIFO
recv_data  input  8  head of the receive FIFO (first-word fall-through)
receivable  input  1  receive FIFO not empty

Behaviour:
- Reset: RST is asynchronous, active-high; clock is CLK. On reset:
  - state = IDLE;
  - req_ready, resp_valid, resp_rdata, resp_err = 0;
  - round-robin pointer favours port 0.
  - RST mid-transaction aborts it silently; no resp_valid is issued.
- send_flag, send_data and recv_flag are combinational from state, so they are 0 in reset.
- States: IDLE, SEND_HDR, SEND_ADDR, SEND_DATA, WAIT_RESP, DONE.
- IDLE:
  - If any req_valid bit is set, grant one port. If both are set, grant the port other than the last granted.
  - Latch write, addr, wdata and mask; pulse req_ready for the grant; go to SEND_HDR.
  - Otherwise, if receivable, pop (recv_flag=1) to drain stray bytes.
- Header byte: bit7 = port id, bit6 = write, bits5:4 = 0, bits3:0 = mask. Reads always send mask 0xF.
- Send states:
  - send_flag = sendable. A byte advances only in a cycle where sendable=1; otherwise the state stalls.
  - SEND_ADDR sends 4 bytes, LSB first. Its 2-bit byte counter wraps 3->0 on exit.
  - Reads go SEND_ADDR -> WAIT_RESP.
  - Writes go to SEND_DATA: 4 bytes, LSB first.
  - After SEND_DATA, go to WAIT_RESP if WRITE_ACK=1, else to DONE.
- WAIT_RESP:
  - recv_flag = receivable; each popped byte is consumed in the same cycle.
  - Read: 4 bytes, assembled little-endian into resp_rdata.
  - Write: 1 ack byte; its value is ignored.
  - After the last byte, go to DONE.
- DONE: pulse resp_valid for the granted port for one cycle; update the round-robin pointer; go to IDLE.
- resp_rdata holds its value until the next read completes. A write returns resp_rdata = 0.
- Minimum latency with the FIFOs always ready:
  - read: grant + 5 send + 4 recv + DONE = 11 cycles;
  - write with ack: 1 + 9 + 1 + 1 = 12 cycles.
- A request arriving during a transaction waits; req_ready never pulses outside IDLE.
- A new grant may occur in the cycle after DONE.

Optional Feature:
UART_MEM_TIMEOUT_EN:
- Defined:
  - A watchdog counter clears on entry to WAIT_RESP and on every popped byte, and increments otherwise.
  - When it reaches TIMEOUT_CYCLES-1, go to DONE with resp_err=1 and resp_rdata=0.
  - Late bytes are later drained in IDLE.
- Undefined: WAIT_RESP waits indefinitely; resp_err is tied to 0.

Decomposition:
- Package uart_mem_pkg holds:
  - state encoding;
  - header bit positions (HDR_ID=7, HDR_WR=6, HDR_MASK=3:0);
  - byte counts (ADDR_BYTES=4, DATA_BYTES=4, ACK_BYTES=1).
- Sub-module rr_arb2: a 2-requester round-robin arbiter with a registered last-grant pointer and an update strobe driven by DONE.

Test Plan:
- Read, port 0, addr 0x00001004:
  - bytes sent 0x0F,0x04,0x10,0x00,0x00;
  - bench replies 0x78,0x56,0x34,0x12;
  - required: resp_valid=01, resp_rdata=0x12345678, resp_err=0, 11 cycles total.
- Write, port 1, addr 0x00000080, wdata 0xDEADBEEF, mask 0x3:
  - bytes sent 0xC3,0x80,0x00,0x00,0x00,0xEF,0xBE,0xAD,0xDE;
  - ack 0x00;
  - required: resp_valid=10.
- Both ports hold reads continuously from reset: grants alternate 0,1,0,1; neither port waits more than one transaction.
- sendable low for 7 cycles mid-address: no send_flag while low; byte sequence unchanged; latency increases by 7.
- 3 stray bytes present in IDLE: all popped before any request; a following read returns the correct data.
- UART_MEM_TIMEOUT_EN with TIMEOUT_CYCLES=16 and no reply: resp_valid and resp_err=1 exactly 16 cycles after entering WAIT_RESP.
- RST asserted mid SEND_ADDR: all outputs 0 immediately; no resp_valid; the next request starts with a header byte.

Source files
------------

// File: rtl/uart_mem_ctrl_pkg.sv
// Shared definitions for the UART memory-access controller:
// FSM state encoding, command header layout and packet byte counts.
package uart_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND_HDR,
        SEND_ADDR,
        SEND_DATA,
        WAIT_RESP,
        DONE
    } state_t;

    // Header byte layout
    localparam int HDR_ID      = 7;
    localparam int HDR_WR      = 6;
    localparam int HDR_MASK_HI = 3;
    localparam int HDR_MASK_LO = 0;

    // Packet byte counts
    localparam int ADDR_BYTES = 4;
    localparam int DATA_BYTES = 4;
    localparam int ACK_BYTES  = 1;

    // Build the command header: port id, write flag, byte mask (bits 5:4 zero)
    function automatic logic [7:0] make_hdr(input logic id, input logic wr, input logic [3:0] mask);
        logic [7:0] hdr;
        hdr                         = 8'h00;
        hdr[HDR_ID]                 = id;
        hdr[HDR_WR]                 = wr;
        hdr[HDR_MASK_HI:HDR_MASK_LO] = mask;
        return hdr;
    endfunction

endpackage

// File: rtl/uart_mem_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter. The registered pointer remembers the
// last served port; on a tie the other port wins. Out of reset port 0 wins.
module rr_arb2 (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       upd_id,
    output logic       gnt_id
);

    logic last_id;

    // Tie goes to the port not served last; a lone request wins outright
    assign gnt_id = (req == 2'b11) ? ~last_id : (req[1] & ~req[0]);

    // Record the port whose transaction just completed
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_id <= 1'b1;
        end else if (update) begin
            last_id <= upd_id;
        end
    end

endmodule

// File: rtl/uart_mem_ctrl.sv
// UART memory-access controller: arbitrates instruction-fetch (port 0) and
// data (port 1) requests onto one uart_comm byte channel, serialises the
// command packet and collects the response.
// Optional feature macro: UART_MEM_TIMEOUT_EN (response watchdog, resp_err).
module uart_mem_ctrl
    import uart_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter bit WRITE_ACK      = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:0]  req_valid,
    input  logic        p0_write,
    input  logic        p1_write,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p0_wdata,
    input  logic [31:0] p1_wdata,
    input  logic [3:0]  p0_mask,
    input  logic [3:0]  p1_mask,
    output logic [1:0]  req_ready,
    output logic [1:0]  resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        send_flag,
    output logic [7:0]  send_data,
    input  logic        sendable,
    output logic        recv_flag,
    input  logic [7:0]  recv_data,
    input  logic        receivable
);

    localparam logic [1:0] ADDR_LAST = 2'(ADDR_BYTES - 1);
    localparam logic [1:0] DATA_LAST = 2'(DATA_BYTES - 1);
    localparam logic [1:0] ACK_LAST  = 2'(ACK_BYTES - 1);
    localparam logic [1:0] RDAT_LAST = 2'(DATA_BYTES - 1);

    state_t      state;
    logic        cur_id;
    logic        cur_write;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_mask;
    logic [1:0]  byte_cnt;
    logic [23:0] rdata_acc;
    logic        arb_id;
    logic [1:0]  port_onehot;
    logic        in_send;
    logic [7:0]  send_byte;

    rr_arb2 u_arb (
        .CLK    (CLK),
        .RST    (RST),
        .req    (req_valid),
        .update (state == DONE),
        .upd_id (cur_id),
        .gnt_id (arb_id)
    );

    assign port_onehot = cur_id ? 2'b10 : 2'b01;
    assign in_send     = (state == SEND_HDR) || (state == SEND_ADDR) || (state == SEND_DATA);
    assign send_flag   = in_send & sendable;
    assign send_data   = send_byte;
    // Pop response bytes while waiting; drain strays in IDLE only when no request is pending
    assign recv_flag   = ~RST & receivable &
                         ((state == WAIT_RESP) || ((state == IDLE) && (req_valid == 2'b00)));

    // Select the outgoing byte for the current send state
    always_comb begin
        // NOTE: default first so every path assigns send_byte; a missing branch would infer a latch.
        send_byte = 8'h00;
        case (state)
            SEND_HDR:  send_byte = make_hdr(cur_id, cur_write, cur_mask);
            SEND_ADDR: send_byte = cur_addr[{byte_cnt, 3'b000} +: 8];
            SEND_DATA: send_byte = cur_wdata[{byte_cnt, 3'b000} +: 8];
            default:   send_byte = 8'h00;
        endcase
    end

`ifdef UART_MEM_TIMEOUT_EN
    logic [31:0] wdog;
    logic        err_q;
    assign resp_err = err_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign resp_err = 1'b0;
`endif

    // Transaction FSM: grant, serialise the command, collect the response
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            req_ready  <= 2'b00;
            resp_valid <= 2'b00;
            resp_rdata <= 32'h0;
            cur_id     <= 1'b0;
            cur_write  <= 1'b0;
            cur_addr   <= 32'h0;
            cur_wdata  <= 32'h0;
            cur_mask   <= 4'h0;
            byte_cnt   <= 2'd0;
            rdata_acc  <= 24'h0;
`ifdef UART_MEM_TIMEOUT_EN
            wdog       <= 32'h0;
            err_q      <= 1'b0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            req_ready  <= 2'b00;
            resp_valid <= 2'b00;
`ifdef UART_MEM_TIMEOUT_EN
            if (state != WAIT_RESP) wdog <= 32'h0;
`endif
            case (state)
                IDLE: begin
                    if (req_valid != 2'b00) begin
                        cur_id    <= arb_id;
                        cur_write <= arb_id ? p1_write : p0_write;
                        cur_addr  <= arb_id ? p1_addr  : p0_addr;
                        cur_wdata <= arb_id ? p1_wdata : p0_wdata;
                        cur_mask  <= arb_id ? (p1_write ? p1_mask : 4'hF)
                                            : (p0_write ? p0_mask : 4'hF);
                        req_ready <= arb_id ? 2'b10 : 2'b01;
                        byte_cnt  <= 2'd0;
`ifdef UART_MEM_TIMEOUT_EN
                        err_q     <= 1'b0;
`endif
                        state     <= SEND_HDR;
                    end
                end
                SEND_HDR: begin
                    if (sendable) state <= SEND_ADDR;
                end
                SEND_ADDR: begin
                    if (sendable) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == ADDR_LAST) state <= cur_write ? SEND_DATA : WAIT_RESP;
                    end
                end
                SEND_DATA: begin
                    if (sendable) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == DATA_LAST) begin
                            if (WRITE_ACK) begin
                                state <= WAIT_RESP;
                            end else begin
                                resp_valid <= port_onehot;
                                resp_rdata <= 32'h0;
                                state      <= DONE;
                            end
                        end
                    end
                end
                WAIT_RESP: begin
                    if (receivable) begin
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef UART_MEM_TIMEOUT_EN
                        wdog     <= 32'h0;
`endif
                        if (cur_write ? (byte_cnt == ACK_LAST) : (byte_cnt == RDAT_LAST)) begin
                            resp_valid <= port_onehot;
                            resp_rdata <= cur_write ? 32'h0 : {recv_data, rdata_acc};
                            state      <= DONE;
                        end else begin
                            rdata_acc <= {recv_data, rdata_acc[23:8]};
                        end
                    end
`ifdef UART_MEM_TIMEOUT_EN
                    else if (wdog == 32'(TIMEOUT_CYCLES - 1)) begin
                        resp_valid <= port_onehot;
                        resp_rdata <= 32'h0;
                        err_q      <= 1'b1;
                        state      <= DONE;
                    end else begin
                        wdog <= wdog + 32'd1;
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mem_ctrl.sv
// Directed testbench for uart_mem_ctrl. The bench models the uart_comm
// send/receive FIFOs with queues; all expected values are hand-computed.
// Define UART_MEM_TIMEOUT_EN to also exercise the response watchdog.
module tb_uart_mem_ctrl;

`ifdef UART_MEM_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1048576;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic        p0_write = 1'b0, p1_write = 1'b0;
    logic [31:0] p0_addr = 32'h0, p1_addr = 32'h0;
    logic [31:0] p0_wdata = 32'h0, p1_wdata = 32'h0;
    logic [3:0]  p0_mask = 4'h0, p1_mask = 4'h0;
    logic [1:0]  req_ready, resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err, send_flag, recv_flag;
    logic [7:0]  send_data;
    logic        sendable = 1'b1;
    logic [7:0]  recv_data = 8'h00;
    logic        receivable = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    bit bad_send = 1'b0;

    uart_mem_ctrl #(.TIMEOUT_CYCLES(TMO), .WRITE_ACK(1'b1)) dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid),
        .p0_write(p0_write), .p1_write(p1_write),
        .p0_addr(p0_addr), .p1_addr(p1_addr),
        .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
        .p0_mask(p0_mask), .p1_mask(p1_mask),
        .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .send_flag(send_flag), .send_data(send_data), .sendable(sendable),
        .recv_flag(recv_flag), .recv_data(recv_data), .receivable(receivable)
    );

    always #5 CLK = ~CLK;

    task automatic rx_sync();
        receivable = (rxq.size() != 0);
        recv_data  = receivable ? rxq[0] : 8'h00;
    endtask

    // Advance one clock: FIFO handshakes sampled at negedge act at the posedge
    task automatic tick();
        logic s_f, s_ok, r_f;
        logic [7:0] s_d;
        @(negedge CLK);
        s_f = send_flag; s_d = send_data; s_ok = sendable; r_f = recv_flag;
        @(posedge CLK);
        #2;
        if (s_f === 1'b1) begin
            txq.push_back(s_d);
            if (!s_ok) bad_send = 1'b1;
        end
        if (r_f === 1'b1 && rxq.size() != 0) void'(rxq.pop_front());
        rx_sync();
    endtask

    task automatic push_reply(input int n, input logic [31:0] val);
        for (int i = 0; i < n; i++) rxq.push_back(val[8*i +: 8]);
        rx_sync();
    endtask

    // Issue one request from IDLE; cyc counts the grant cycle as 1 through the DONE cycle
    task automatic run_txn(input bit port, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mask,
                           input int stall_at, output int cyc, output logic [1:0] rv,
                           output logic [31:0] rd, output logic err, output logic [1:0] rr_seen);
        int stall_cnt = 0;
        bit stalled = 1'b0;
        txq.delete();
        bad_send = 1'b0;
        if (port) begin p1_write = wr; p1_addr = addr; p1_wdata = wdata; p1_mask = mask; end
        else      begin p0_write = wr; p0_addr = addr; p0_wdata = wdata; p0_mask = mask; end
        req_valid[port] = 1'b1;
        cyc = 1; rv = 2'b00; rd = 32'h0; err = 1'b0; rr_seen = 2'b00;
        for (int i = 0; i < 200; i++) begin
            tick();
            cyc++;
            if (req_ready != 2'b00) begin
                rr_seen = rr_seen | req_ready;
                req_valid = 2'b00;
            end
            if (stall_cnt > 0) begin
                stall_cnt--;
                if (stall_cnt == 0) sendable = 1'b1;
            end
            if (stall_at >= 0 && !stalled && txq.size() == stall_at) begin
                stalled = 1'b1;
                sendable = 1'b0;
                stall_cnt = 7;
            end
            if (resp_valid != 2'b00) begin
                rv = resp_valid; rd = resp_rdata; err = resp_err;
                break;
            end
        end
        req_valid = 2'b00;
        sendable = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #1;
        if ({req_ready, resp_valid, resp_err, send_flag, recv_flag} !== 7'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 0", {req_ready, resp_valid, resp_err, send_flag, recv_flag});
        end
        checks++;
        if (resp_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h expected 0", resp_rdata);
        end
        checks++;
        repeat (3) tick();
        RST = 1'b0;
        repeat (2) tick();
        if ({req_ready, resp_valid, send_flag, recv_flag} !== 6'b0) begin
            errors++; $display("FAIL idle_outputs: got %b expected 0", {req_ready, resp_valid, send_flag, recv_flag});
        end
        checks++;
    endtask

    task automatic test_read();
        logic [7:0] exp_b[5] = '{8'h0F, 8'h04, 8'h10, 8'h00, 8'h00};
        int cyc; logic [1:0] rv, rr; logic [31:0] rd; logic err;
        push_reply(4, 32'h12345678);
        run_txn(1'b0, 1'b0, 32'h00001004, 32'h0, 4'h0, -1, cyc, rv, rd, err, rr);
        if (txq.size() != 5) begin errors++; $display("FAIL read_nbytes: got %0d expected 5", txq.size()); end
        checks++;
        for (int i = 0; i < 5; i++) begin
            if (txq[i] !== exp_b[i]) begin errors++; $display("FAIL read_byte%0d: got %h expected %h", i, txq[i], exp_b[i]); end
            checks++;
        end
        if (rr !== 2'b01) begin errors++; $display("FAIL read_ready: got %b expected 01", rr); end
        checks++;
        if (rv !== 2'b01) begin errors++; $display("FAIL read_valid: got %b expected 01", rv); end
        checks++;
        if (rd !== 32'h12345678) begin errors++; $display("FAIL read_rdata: got %h expected 12345678", rd); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL read_err: got %b expected 0", err); end
        checks++;
        if (cyc != 11) begin errors++; $display("FAIL read_latency: got %0d expected 11", cyc); end
        checks++;
    endtask

    task automatic test_write();
        logic [7:0] exp_b[9] = '{8'hC3, 8'h80, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        int cyc; logic [1:0] rv, rr; logic [31:0] rd; logic err;
        push_reply(1, 32'h0);
        run_txn(1'b1, 1'b1, 32'h00000080, 32'hDEADBEEF, 4'h3, -1, cyc, rv, rd, err, rr);
        if (txq.size() != 9) begin errors++; $display("FAIL write_nbytes: got %0d expected 9", txq.size()); end
        checks++;
        for (int i = 0; i < 9; i++) begin
            if (txq[i] !== exp_b[i]) begin errors++; $display("FAIL write_byte%0d: got %h expected %h", i, txq[i], exp_b[i]); end
            checks++;
        end
        if (rv !== 2'b10) begin errors++; $display("FAIL write_valid: got %b expected 10", rv); end
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL write_rdata: got %h expected 0", rd); end
        checks++;
        if (cyc != 12) begin errors++; $display("FAIL write_latency: got %0d expected 12", cyc); end
        checks++;
        if (rxq.size() != 0) begin errors++; $display("FAIL write_ack_popped: got %0d left expected 0", rxq.size()); end
        checks++;
    endtask

    task automatic test_back_to_back();
        logic [1:0]  grants[$];
        logic [1:0]  resps[$];
        logic [31:0] datas[$];
        logic [1:0]  exp_p;
        logic [7:0]  exp_h;
        txq.delete();
        p0_write = 1'b0; p0_addr = 32'h00000100;
        p1_write = 1'b0; p1_addr = 32'h00000200;
        for (int k = 0; k < 4; k++) push_reply(4, 32'hC0DE0000 | k);
        req_valid = 2'b11;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (req_ready != 2'b00) grants.push_back(req_ready);
            if (resp_valid != 2'b00) begin
                resps.push_back(resp_valid);
                datas.push_back(resp_rdata);
                if (resps.size() == 4) break;
            end
        end
        req_valid = 2'b00;
        tick();
        if (resps.size() != 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", resps.size()); end
        checks++;
        for (int k = 0; k < 4; k++) begin
            exp_p = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_h = (k % 2 == 0) ? 8'h0F : 8'h8F;
            if (grants[k] !== exp_p) begin errors++; $display("FAIL b2b_grant%0d: got %b expected %b", k, grants[k], exp_p); end
            checks++;
            if (resps[k] !== exp_p) begin errors++; $display("FAIL b2b_resp%0d: got %b expected %b", k, resps[k], exp_p); end
            checks++;
            if (datas[k] !== (32'hC0DE0000 | k)) begin errors++; $display("FAIL b2b_rdata%0d: got %h expected %h", k, datas[k], 32'hC0DE0000 | k); end
            checks++;
            if (txq[5*k] !== exp_h) begin errors++; $display("FAIL b2b_hdr%0d: got %h expected %h", k, txq[5*k], exp_h); end
            checks++;
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp_b[5] = '{8'h8F, 8'hD4, 8'hC3, 8'hB2, 8'hA1};
        int cyc; logic [1:0] rv, rr; logic [31:0] rd; logic err;
        push_reply(4, 32'h0BADF00D);
        run_txn(1'b1, 1'b0, 32'hA1B2C3D4, 32'h0, 4'h0, 2, cyc, rv, rd, err, rr);
        if (bad_send) begin errors++; $display("FAIL stall_send_flag: got send while sendable low expected none"); end
        checks++;
        for (int i = 0; i < 5; i++) begin
            if (txq[i] !== exp_b[i]) begin errors++; $display("FAIL stall_byte%0d: got %h expected %h", i, txq[i], exp_b[i]); end
            checks++;
        end
        if (cyc != 18) begin errors++; $display("FAIL stall_latency: got %0d expected 18", cyc); end
        checks++;
        if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL stall_rdata: got %h expected 0badf00d", rd); end
        checks++;
    endtask

    task automatic test_stray();
        int cyc; logic [1:0] rv, rr; logic [31:0] rd; logic err;
        logic [1:0] seen = 2'b00;
        rxq.push_back(8'hAA); rxq.push_back(8'hBB); rxq.push_back(8'hCC);
        rx_sync();
        for (int i = 0; i < 3; i++) begin
            tick();
            seen = seen | resp_valid | req_ready;
        end
        if (rxq.size() != 0) begin errors++; $display("FAIL stray_drain: got %0d left expected 0", rxq.size()); end
        checks++;
        if (seen !== 2'b00) begin errors++; $display("FAIL stray_quiet: got %b expected 00", seen); end
        checks++;
        push_reply(4, 32'hCAFEF00D);
        run_txn(1'b1, 1'b0, 32'h00000010, 32'h0, 4'h0, -1, cyc, rv, rd, err, rr);
        if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL stray_rdata: got %h expected cafef00d", rd); end
        checks++;
        if (rv !== 2'b10) begin errors++; $display("FAIL stray_valid: got %b expected 10", rv); end
        checks++;
    endtask

    task automatic test_reset_mid();
        int cyc; logic [1:0] rv, rr; logic [31:0] rd; logic err;
        logic [1:0] seen = 2'b00;
        bit hit = 1'b0;
        txq.delete();
        p0_write = 1'b0; p0_addr = 32'h00000300;
        req_valid = 2'b01;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (req_ready != 2'b00) req_valid = 2'b00;
            if (txq.size() == 2) begin hit = 1'b1; break; end
        end
        if (!hit || send_flag !== 1'b1) begin errors++; $display("FAIL rstmid_reach: got send_flag %b expected 1 in address phase", send_flag); end
        checks++;
        RST = 1'b1;
        #1;
        if ({req_ready, resp_valid, resp_err, send_flag, recv_flag} !== 7'b0 || resp_rdata !== 32'h0) begin
            errors++; $display("FAIL rstmid_outputs: got %b/%h expected 0", {req_ready, resp_valid, resp_err, send_flag, recv_flag}, resp_rdata);
        end
        checks++;
        req_valid = 2'b00;
        repeat (2) tick();
        RST = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen = seen | resp_valid;
        end
        if (seen !== 2'b00) begin errors++; $display("FAIL rstmid_no_resp: got %b expected 00", seen); end
        checks++;
        push_reply(4, 32'h55AA1234);
        run_txn(1'b1, 1'b0, 32'h00000400, 32'h0, 4'h0, -1, cyc, rv, rd, err, rr);
        if (txq[0] !== 8'h8F) begin errors++; $display("FAIL rstmid_hdr: got %h expected 8f", txq[0]); end
        checks++;
        if (rd !== 32'h55AA1234) begin errors++; $display("FAIL rstmid_rdata: got %h expected 55aa1234", rd); end
        checks++;
    endtask

`ifdef UART_MEM_TIMEOUT_EN
    task automatic test_timeout();
        int cyc; logic [1:0] rv, rr; logic [31:0] rd; logic err;
        run_txn(1'b0, 1'b0, 32'h00000500, 32'h0, 4'h0, -1, cyc, rv, rd, err, rr);
        if (rv !== 2'b01) begin errors++; $display("FAIL tmo_valid: got %b expected 01", rv); end
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b expected 1", err); end
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL tmo_rdata: got %h expected 0", rd); end
        checks++;
        if (cyc != 23) begin errors++; $display("FAIL tmo_latency: got %0d expected 23", cyc); end
        checks++;
        push_reply(1, 32'h77);
        repeat (2) tick();
        if (rxq.size() != 0) begin errors++; $display("FAIL tmo_late_drain: got %0d left expected 0", rxq.size()); end
        checks++;
    endtask
`endif

    initial begin
        rx_sync();
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_stall();
        test_stray();
        test_reset_mid();
`ifdef UART_MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
